pattern_scan_ctrl: RTL and testbench

//  Sequencer for the serial Mealy pattern detector. Accepts a parallel word over a

---
 rtl/pattern_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Sequencer for a serial Mealy pattern detector. It accepts a word over a
//   valid/ready handshake. It then flushes the detector with FLUSH_LEN zero bits
//   and shifts the word out LSB-first, one bit per clock. It counts the
//   detector's two hit flags in saturating counters and presents both counts
//   over a second valid/ready handshake.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     word handshake (in_ready high only while idle)
//   in_word               word to scan, bit 0 sent first
//   det_i, det_en         serial bit and enable driven to the detector
//   det_o                 detector hit flags (registered, 1-cycle latency)
//   out_valid/out_ready   result handshake, result held until accepted
//   cnt_a, cnt_b          saturating counts of sampled det_o[1] / det_o[0]
//   busy                  controller not idle
//   first_hit_vld/_pos    (only with SCAN_FIRST_HIT_EN) index of earliest sample
//                         with any flag set
//
// Build option: define SCAN_FIRST_HIT_EN to add the first-hit outputs.
module pattern_scan_ctrl #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned FLUSH_LEN = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_word,
    output logic                      det_i,
    output logic                      det_en,
    input  logic [1:0]                det_o,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          cnt_a,
    output logic [CNT_W-1:0]          cnt_b,
`ifdef SCAN_FIRST_HIT_EN
    output logic                      first_hit_vld,
    output logic [$clog2(WORD_W)-1:0] first_hit_pos,
`endif
    output logic                      busy
);

    localparam int unsigned IdxMax = (WORD_W > FLUSH_LEN) ? WORD_W : FLUSH_LEN;
    localparam int unsigned IdxW   = $clog2(IdxMax);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [2:0] {StIdle, StFlush, StShift, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
    // det_o reflects the bit driven one cycle earlier, so sampling lags SHIFT by one.
    logic                samp_q, samp_d;

`ifdef SCAN_FIRST_HIT_EN
    localparam int unsigned PosW = $clog2(WORD_W);
    logic [PosW-1:0]     samp_idx_q, samp_idx_d;
    logic                fh_vld_q, fh_vld_d;
    logic [PosW-1:0]     fh_pos_q, fh_pos_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            shift_q    <= '0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
            samp_q     <= 1'b0;
`ifdef SCAN_FIRST_HIT_EN
            samp_idx_q <= '0;
            fh_vld_q   <= 1'b0;
            fh_pos_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            samp_q     <= samp_d;
`ifdef SCAN_FIRST_HIT_EN
            samp_idx_q <= samp_idx_d;
            fh_vld_q   <= fh_vld_d;
            fh_pos_q   <= fh_pos_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        samp_d  = (state_q == StShift);
`ifdef SCAN_FIRST_HIT_EN
        samp_idx_d = samp_idx_q;
        fh_vld_d   = fh_vld_q;
        fh_pos_d   = fh_pos_q;
`endif

        // Qualified samples only occur in SHIFT/DRAIN, never alongside an accept.
        if (samp_q) begin
            if (det_o[1] && (cnt_a_q != CntMax)) cnt_a_d = cnt_a_q + CNT_W'(1);
            if (det_o[0] && (cnt_b_q != CntMax)) cnt_b_d = cnt_b_q + CNT_W'(1);
`ifdef SCAN_FIRST_HIT_EN
            if (!fh_vld_q && (det_o != 2'b00)) begin
                fh_vld_d = 1'b1;
                fh_pos_d = samp_idx_q;
            end
            samp_idx_d = samp_idx_q + PosW'(1);
`endif
        end

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_d = in_word;
                    idx_d   = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
`ifdef SCAN_FIRST_HIT_EN
                    samp_idx_d = '0;
                    fh_vld_d   = 1'b0;
                    fh_pos_d   = '0;
`endif
                    state_d = (FLUSH_LEN == 0) ? StShift : StFlush;
                end
            end
            StFlush: begin
                if (idx_q == IdxW'(FLUSH_LEN - 1)) begin
                    idx_d   = '0;
                    state_d = StShift;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StShift: begin
                shift_d = shift_q >> 1;
                if (idx_q == IdxW'(WORD_W - 1)) begin
                    state_d = StDrain;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDrain: state_d = StDone;
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign det_en    = (state_q == StFlush) || (state_q == StShift);
    assign det_i     = (state_q == StShift) && shift_q[0];
    assign out_valid = (state_q == StDone);
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;
`ifdef SCAN_FIRST_HIT_EN
    assign first_hit_vld = fh_vld_q;
    assign first_hit_pos = fh_pos_q;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: two instances (CNT_W=4 and CNT_W=2) share the
// stimulus, each looped through a stub detector det_o <= {det_i, ~det_i}.
module tb_pattern_scan_ctrl;

    localparam int unsigned WORD_W    = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned FLUSH_LEN = 2;
    localparam int unsigned LAT       = FLUSH_LEN + WORD_W + 1;
    localparam int unsigned SEQ_N     = FLUSH_LEN + WORD_W;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [WORD_W-1:0] in_word = '0;

    logic              in_ready, det_i, det_en, out_valid, busy;
    logic [1:0]        det_o;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic              in_ready2, det_i2, det_en2, out_valid2, busy2;
    logic [1:0]        det_o2;
    logic [1:0]        cnt_a2, cnt_b2;
`ifdef SCAN_FIRST_HIT_EN
    logic                      fh_vld, fh_vld2;
    logic [$clog2(WORD_W)-1:0] fh_pos, fh_pos2;
`endif

    int errors = 0;
    int checks = 0;

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .FLUSH_LEN(FLUSH_LEN)) u_dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .det_i(det_i), .det_en(det_en), .det_o(det_o),
        .out_valid(out_valid), .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b),
`ifdef SCAN_FIRST_HIT_EN
        .first_hit_vld(fh_vld), .first_hit_pos(fh_pos),
`endif
        .busy(busy)
    );

    pattern_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2), .FLUSH_LEN(FLUSH_LEN)) u_dut_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_word(in_word), .det_i(det_i2), .det_en(det_en2), .det_o(det_o2),
        .out_valid(out_valid2), .out_ready(out_ready), .cnt_a(cnt_a2), .cnt_b(cnt_b2),
`ifdef SCAN_FIRST_HIT_EN
        .first_hit_vld(fh_vld2), .first_hit_pos(fh_pos2),
`endif
        .busy(busy2)
    );

    always #5 clock = ~clock;

    // Stub detector: registered {det_i, ~det_i}.
    always @(posedge clock) begin
        det_o  <= {det_i, ~det_i};
        det_o2 <= {det_i2, ~det_i2};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    // Earliest bit index whose stub response {b, ~b} has any flag set.
    function automatic int first_hit_model(input logic [WORD_W-1:0] w);
        for (int k = 0; k < int'(WORD_W); k++) begin
            if ({w[k], ~w[k]} != 2'b00) return k;
        end
        return 0;
    endfunction

    task automatic run_word(input logic [WORD_W-1:0] w, input int hold, input bit intrude);
        int lat;
        int n;
        int exp_a;
        int exp_b;
        logic [SEQ_N-1:0] seq;
        logic [SEQ_N-1:0] exp_seq;

        check_eq("pre_in_ready", in_ready, 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        in_word   = w;
        step();
        in_valid  = 1'b0;
        in_word   = WORD_W'($urandom);
        lat = 0;
        n   = 0;
        seq = '0;
        while (!out_valid && lat < int'(4 * LAT)) begin
            if (det_en) begin
                if (n < int'(SEQ_N)) seq[n] = det_i;
                n++;
            end
            if (intrude && lat == int'(FLUSH_LEN) + 3) begin
                check_eq("busy_in_ready", in_ready, 0);
                in_valid = 1'b1;
                in_word  = 8'h0F;
            end else begin
                in_valid = 1'b0;
            end
            step();
            lat++;
        end
        in_valid = 1'b0;

        exp_seq = '0;
        exp_seq[FLUSH_LEN +: WORD_W] = w;
        exp_a = $countones(w);
        exp_b = int'(WORD_W) - exp_a;
        check_eq("latency", lat, LAT);
        check_eq("det_en_pulses", n, SEQ_N);
        check_eq("det_i_seq", seq, exp_seq);
        check_eq("cnt_a", cnt_a, sat(exp_a, CNT_W));
        check_eq("cnt_b", cnt_b, sat(exp_b, CNT_W));
        check_eq("cnt_a_sat", cnt_a2, sat(exp_a, 2));
        check_eq("cnt_b_sat", cnt_b2, sat(exp_b, 2));
        check_eq("done_busy", busy, 1);
        check_eq("done_in_ready", in_ready, 0);
`ifdef SCAN_FIRST_HIT_EN
        check_eq("first_hit_vld", fh_vld, 1);
        check_eq("first_hit_pos", fh_pos, first_hit_model(w));
`endif
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_cnt_a", cnt_a, sat(exp_a, CNT_W));
            check_eq("hold_cnt_b", cnt_b, sat(exp_b, CNT_W));
        end
        out_ready = 1'b1;
        step();
        check_eq("post_out_valid", out_valid, 0);
        check_eq("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int bad;

        repeat (3) step();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("idle_in_ready", in_ready, 1);
            check_eq("idle_det_en", det_en, 0);
            check_eq("idle_det_i", det_i, 0);
            check_eq("idle_out_valid", out_valid, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_cnt", {cnt_a, cnt_b}, 0);
        end

        run_word(8'hB5, 0, 1'b0);
        run_word(8'hFF, 0, 1'b0);
        run_word(8'h00, 0, 1'b0);
        run_word(8'h5A, 5, 1'b1);
        run_word(8'h10, 0, 1'b0);
        repeat (20) begin
            run_word(WORD_W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of SHIFT.
        in_valid = 1'b1;
        in_word  = 8'hFF;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check_eq("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_in_ready", in_ready, 1);
        check_eq("rst_mid_cnt", {cnt_a, cnt_b}, 0);
        check_eq("rst_mid_det_en", det_en, 0);
        check_eq("rst_mid_out_valid", out_valid, 0);
        step();
        reset_n = 1'b1;
        bad = 0;
        repeat (3 * LAT) begin
            step();
            if (out_valid || busy) bad++;
        end
        check_eq("no_partial_result", bad, 0);

        run_word(8'hB5, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
